mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit that answers the control unit's multiply and divide requests. It takes a one-cycle start pulse plus the A/B register operands, iterates for a fixed number of cycles, and then returns a one-cycle `done` pulse together with a 64-bit result split into `hi` and `lo`. It sits beside the ALU in the datapath, and its `hi`/`lo` outputs feed the HI/LO registers. Divide-by-zero is flagged so the control unit can take the exception path.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/div_step.sv | 33 +++
 rtl/mult_div_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle signed multiply/divide unit.
package mult_div_pkg;

   // Default operand width; results are twice this wide.
   localparam int DEFAULT_WIDTH = 32;

   // Width of the iteration counter shared by multiply and divide.
   localparam int CNT_W = 6;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MULT   = 2'd1,
      ST_DIV    = 2'd2,
      ST_FINISH = 2'd3
   } md_state_t;

   // Full-width result as delivered to the HI/LO register pair.
   typedef logic [2*DEFAULT_WIDTH-1:0] result_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder and subtract the
// divisor when it fits.
module div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             next_bit,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // The shifted partial remainder needs one extra bit before the compare.
   logic [WIDTH:0] partial_s;
   logic [WIDTH:0] diff_s;

   // Trial subtraction; keep the difference only when it does not go negative.
   always_comb begin
      partial_s = {rem_in, next_bit};
      diff_s    = partial_s - {1'b0, divisor};
      if (partial_s >= {1'b0, divisor}) begin
         q_bit   = 1'b1;
         rem_out = diff_s[WIDTH-1:0];
      end else begin
         q_bit   = 1'b0;
         rem_out = partial_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) unit.
// A start pulse in IDLE launches ITER iteration cycles, then FINISH registers
// hi/lo and pulses done. Divide by zero skips straight to FINISH.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   // Two's complement negation at operand width.
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return (~v) + ONE_W;
   endfunction

   // Magnitude of a signed operand; the most negative value maps to itself,
   // which is correct when read as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? negate(v) : v;
   endfunction

   md_state_t        state_r;
   md_state_t        state_nxt_s;
   logic [CNT_W-1:0] cnt_r;

   logic accept_mult_s;
   logic accept_div_s;
   logic div_by_zero_s;
   logic last_iter_s;

   // Booth register layout: {acc (WIDTH+1), multiplier (WIDTH), q_minus_1}.
   // The accumulator carries a guard bit so subtracting the most negative
   // multiplicand cannot overflow.
   logic [WIDTH-1:0]   mcand_r;
   logic [2*WIDTH+1:0] booth_r;
   logic [2*WIDTH+1:0] booth_nxt_s;
   logic [WIDTH:0]     acc_s;
   logic [WIDTH:0]     mcand_ext_s;
   logic [WIDTH:0]     acc_new_s;

   // Divide datapath: quotient register initially holds the dividend magnitude
   // and shifts it out MSB first while quotient bits shift in.
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvsr_r;
   logic [WIDTH-1:0] step_rem_s;
   logic             step_q_s;
   logic             sign_a_r;
   logic             sign_b_r;
   logic             is_div_r;
   logic             dz_r;

   logic             busy_r;
   logic             done_r;
   logic             div_zero_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_in   (rem_r),
      .divisor  (dvsr_r),
      .next_bit (quo_r[WIDTH-1]),
      .rem_out  (step_rem_s),
      .q_bit    (step_q_s)
   );

   // Start qualification: only in IDLE, multiply has priority over divide.
   always_comb begin
      accept_mult_s = (state_r == ST_IDLE) && mult_start;
      accept_div_s  = (state_r == ST_IDLE) && div_start && !mult_start;
      div_by_zero_s = accept_div_s && (op_b == {WIDTH{1'b0}});
      last_iter_s   = (cnt_r == LAST_CNT);
   end

   // Next-state logic for the sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_mult_s) begin
               state_nxt_s = ST_MULT;
            end else if (div_by_zero_s) begin
               state_nxt_s = ST_FINISH;
            end else if (accept_div_s) begin
               state_nxt_s = ST_DIV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (last_iter_s) begin
               state_nxt_s = ST_FINISH;
            end else begin
               state_nxt_s = ST_MULT;
            end
         end
         ST_DIV: begin
            if (last_iter_s) begin
               state_nxt_s = ST_FINISH;
            end else begin
               state_nxt_s = ST_DIV;
            end
         end
         ST_FINISH: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // One Booth step: add/sub the multiplicand per {m0, q-1}, then shift right
   // arithmetically across the whole register.
   always_comb begin
      acc_s       = booth_r[2*WIDTH+1:WIDTH+1];
      mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
      case (booth_r[1:0])
         2'b01:   acc_new_s = acc_s + mcand_ext_s;
         2'b10:   acc_new_s = acc_s - mcand_ext_s;
         default: acc_new_s = acc_s;
      endcase
      booth_nxt_s = {acc_new_s[WIDTH], acc_new_s, booth_r[WIDTH:1]};
   end

   // Operand capture at the start edge and per-cycle iteration of both datapaths.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         cnt_r    <= {CNT_W{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         booth_r  <= {(2*WIDTH+2){1'b0}};
         rem_r    <= {WIDTH{1'b0}};
         quo_r    <= {WIDTH{1'b0}};
         dvsr_r   <= {WIDTH{1'b0}};
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         is_div_r <= 1'b0;
         dz_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_mult_s) begin
                  cnt_r    <= {CNT_W{1'b0}};
                  mcand_r  <= op_a;
                  booth_r  <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
                  is_div_r <= 1'b0;
                  dz_r     <= 1'b0;
               end else if (accept_div_s) begin
                  cnt_r    <= {CNT_W{1'b0}};
                  rem_r    <= {WIDTH{1'b0}};
                  quo_r    <= magnitude(op_a);
                  dvsr_r   <= magnitude(op_b);
                  sign_a_r <= op_a[WIDTH-1];
                  sign_b_r <= op_b[WIDTH-1];
                  is_div_r <= 1'b1;
                  dz_r     <= div_by_zero_s;
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            ST_MULT: begin
               booth_r <= booth_nxt_s;
               cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ST_DIV: begin
               rem_r <= step_rem_s;
               quo_r <= {quo_r[WIDTH-2:0], step_q_s};
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Output registers: busy tracks the operation, FINISH publishes the result.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
      end else begin
         busy_r     <= (state_r != ST_IDLE) || accept_mult_s || accept_div_s;
         done_r     <= (state_r == ST_FINISH);
         div_zero_r <= (state_r == ST_FINISH) && dz_r;
         if (state_r == ST_FINISH) begin
            if (dz_r) begin
               hi_r <= hi_r;
               lo_r <= lo_r;
            end else if (is_div_r) begin
               lo_r <= (sign_a_r ^ sign_b_r) ? negate(quo_r) : quo_r;
               hi_r <= sign_a_r ? negate(rem_r) : rem_r;
            end else begin
               hi_r <= booth_r[2*WIDTH:WIDTH+1];
               lo_r <= booth_r[WIDTH:1];
            end
         end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          reset_in;
   logic          mult_start;
   logic          div_start;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_tests = 0;
   int n_fail  = 0;

   // Model copy of the HI/LO pair, needed because divide-by-zero keeps it.
   logic [W-1:0] m_hi = 32'h0;
   logic [W-1:0] m_lo = 32'h0;

   typedef struct {
      bit           is_div;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eh;
      logic [W-1:0] el;
      bit           edz;
   } vec_t;

   vec_t vecs[$];

   mult_div_unit dut (
      .clk        (clk),
      .reset_in   (reset_in),
      .mult_start (mult_start),
      .div_start  (div_start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit signed arithmetic (C-style truncating division).
   function automatic void model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
      longint sa;
      longint sb;
      logic [63:0] p;
      logic [63:0] q;
      logic [63:0] r;
      sa  = $signed(a);
      sb  = $signed(b);
      edz = 1'b0;
      if (!is_div) begin
         p  = sa * sb;
         eh = p[63:32];
         el = p[31:0];
      end else if (b == 32'h0) begin
         eh  = m_hi;
         el  = m_lo;
         edz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         el = q[31:0];
         eh = r[31:0];
      end
      m_hi = eh;
      m_lo = el;
   endfunction

   // Called at a negedge; pulses the start(s), scrambles operands afterwards,
   // and returns at the negedge where done is seen (or after the cycle bound).
   task automatic do_op(input bit ms, input bit ds, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic dz);
      mult_start = ms;
      div_start  = ds;
      op_a       = a;
      op_b       = b;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      op_a       = $urandom;
      op_b       = $urandom;
      lat        = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      h  = hi;
      l  = lo;
      dz = div_zero;
   endtask

   task automatic run_check(input string name, input bit ms, input bit ds,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el, h, l;
      logic edz, dz;
      int lat;
      model(ms ? 1'b0 : ds, a, b, eh, el, edz);
      do_op(ms, ds, a, b, lat, h, l, dz);
      check({name, " latency"}, lat, edz ? 1 : LAT);
      check({name, " hi"}, h, eh);
      check({name, " lo"}, l, el);
      check({name, " div_zero"}, dz, edz);
   endtask

   // At the done cycle busy must be high; one cycle later both are low.
   task automatic finish_idle(input string name);
      check({name, " busy@done"}, busy, 1'b1);
      @(negedge clk);
      check({name, " done pulse"}, done, 1'b0);
      check({name, " busy idle"}, busy, 1'b0);
      check({name, " div_zero idle"}, div_zero, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] h, l, a, b;
      int nd;
      bit is_div;

      reset_in   = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      op_a       = 32'h0;
      op_b       = 32'h0;
      repeat (2) @(negedge clk);
      check("reset outputs", {busy, done, div_zero, hi, lo}, 67'h0);
      reset_in = 1'b1;
      @(negedge clk);

      // Directed vectors; order matters for the divide-by-zero entry.
      vecs.push_back('{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
      vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
      vecs.push_back('{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0});
      vecs.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
      vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
      vecs.push_back('{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0});
      vecs.push_back('{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0});
      vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0});
      vecs.push_back('{1'b1, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000, 1'b0});
      vecs.push_back('{1'b1, 32'h0000005F, 32'h0000000A, 32'h00000005, 32'h00000009, 1'b0});
      vecs.push_back('{1'b1, 32'h00001234, 32'h00000000, 32'h00000005, 32'h00000009, 1'b1});
      vecs.push_back('{1'b1, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         logic dz;
         int lat;
         string nm;
         nm = $sformatf("vec%0d", i);
         do_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, lat, h, l, dz);
         check({nm, " latency"}, lat, vecs[i].edz ? 1 : LAT);
         check({nm, " hi"}, h, vecs[i].eh);
         check({nm, " lo"}, l, vecs[i].el);
         check({nm, " div_zero"}, dz, vecs[i].edz);
         finish_idle(nm);
         m_hi = vecs[i].eh;
         m_lo = vecs[i].el;
      end

      // Starts while busy are ignored: one done, multiply result only.
      mult_start = 1'b1;
      op_a       = 32'd2;
      op_b       = 32'd3;
      @(negedge clk);
      mult_start = 1'b0;
      nd = 0;
      h  = 32'hDEAD;
      l  = 32'hBEEF;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            nd++;
            h = hi;
            l = lo;
         end
         div_start  = (c == 10);
         mult_start = (c == 20);
         if (c == 10 || c == 20) begin
            op_a = 32'd100;
            op_b = 32'd7;
         end
      end
      check("midop done count", nd, 1);
      check("midop hi", h, 32'h0);
      check("midop lo", l, 32'd6);
      m_hi = 32'h0;
      m_lo = 32'd6;

      // Simultaneous starts: multiply wins.
      run_check("simul", 1'b1, 1'b1, 32'd6, 32'd4);
      finish_idle("simul");

      // Back-to-back: new start in the cycle done is high.
      run_check("b2b first", 1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
      run_check("b2b second", 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3);
      finish_idle("b2b");

      // Reset in the middle of a multiply.
      mult_start = 1'b1;
      op_a       = 32'd5;
      op_b       = 32'd9;
      @(negedge clk);
      mult_start = 1'b0;
      repeat (15) @(negedge clk);
      reset_in = 1'b0;
      #1;
      check("reset midop outputs", {busy, done, div_zero, hi, lo}, 67'h0);
      nd = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      reset_in = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      check("reset no done", nd, 0);
      m_hi = 32'h0;
      m_lo = 32'h0;
      run_check("after reset", 1'b1, 1'b0, 32'd5, 32'd9);
      finish_idle("after reset");

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         is_div = ($urandom_range(0, 1) == 1);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = is_div ? 32'h0 : 32'h80000000;
            2: b = $urandom_range(0, 15) - 8;
            default: a = a;
         endcase
         run_check($sformatf("rnd%0d", i), !is_div, is_div, a, b);
         finish_idle($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
